// File: rtl/pipes_scroller.sv
// pipes_scroller: per-frame game-logic stage in front of the pipe list.
// On each frame tick it walks the list once, scrolling every pipe left,
// dropping pipes that have left the screen and pulsing score_inc when a
// pipe's right edge crosses the bird column. After the walk it may spawn
// a new pipe at the right edge, with the gap height taken from an LFSR.
`timescale 1ns/1ps

module pipes_scroller #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int PIPE_WIDTH     = 64,
    parameter int SPEED          = 2,
    parameter int BIRD_X         = 160,
    parameter int SPAWN_INTERVAL = 100,
    parameter int GAP_MIN        = 64,
    parameter int GAP_RANGE      = 288,
    parameter int MAX_PIPES      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        frame_tick,
    input  logic [4:0]  count,
    output logic        insert_en,
    output logic [20:0] insert_data,
    output logic        iter_start,
    input  logic [20:0] iter_out,
    input  logic        iter_out_valid,
    output logic [20:0] iter_in,
    output logic        iter_remove,
    output logic        score_inc,
    output logic        busy,
    output logic        frame_done
);

    // x is the signed left-edge column, gap_y the gap height
    typedef struct packed {
        logic signed [10:0] x;
        logic        [9:0]  gap_y;
    } pipe_t;

    typedef enum logic [2:0] {IDLE, START, WAIT, ITER, SPAWN, DONE} state_t;

    // All x arithmetic is done in 12-bit signed so x + PIPE_WIDTH cannot wrap
    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic signed [11:0] PW_S    = 12'(PIPE_WIDTH);
    localparam logic signed [11:0] BIRD_S  = 12'(BIRD_X);
    localparam logic [7:0]         SPAWN_LAST = 8'(SPAWN_INTERVAL - 1);
    localparam logic [9:0]         GAP_RANGE_V = 10'(GAP_RANGE);

    state_t      state, state_nxt;
    logic        pending;
    logic [7:0]  spawn_cnt;
    logic [15:0] lfsr;

    pipe_t              cur;
    pipe_t              upd;
    pipe_t              spawn_pipe;
    logic signed [11:0] cur_x;
    logic signed [11:0] nx;
    logic               spawn_due;
    logic               list_room;
    logic               do_spawn;
    logic [9:0]         raw;
    logic [9:0]         gap_off;
    logic               lfsr_fb;

    assign cur   = pipe_t'(iter_out);
    assign cur_x = {cur.x[10], cur.x};
    assign nx    = cur_x - SPEED_S;

    // The scrolled pipe keeps its gap; nx is always in 11-bit range when kept
    assign upd.x     = nx[10:0];
    assign upd.gap_y = cur.gap_y;
    assign iter_in   = upd;

    // Fold the 9-bit LFSR sample into [0, GAP_RANGE) with one subtraction;
    // GAP_RANGE >= 256 guarantees a single fold is enough
    assign raw     = {1'b0, lfsr[8:0]};
    assign gap_off = (raw >= GAP_RANGE_V) ? raw - GAP_RANGE_V : raw;
    assign spawn_pipe.x     = 11'(SCREEN_WIDTH);
    assign spawn_pipe.gap_y = 10'(GAP_MIN) + gap_off;
    assign insert_data      = spawn_pipe;

    assign spawn_due = (spawn_cnt >= SPAWN_LAST);
    assign list_room = (int'(count) < MAX_PIPES);
    assign do_spawn  = spawn_due && list_room;

    assign busy    = (state != IDLE);
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Next-state and per-state outputs; the walk outputs are combinational
    // on iter_out so the list can write back in the same cycle
    always_comb begin
        state_nxt   = state;
        iter_start  = 1'b0;
        iter_remove = 1'b0;
        score_inc   = 1'b0;
        insert_en   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE:  if (frame_tick || pending) state_nxt = START;
            START: begin
                iter_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT:  state_nxt = ITER;
            ITER: begin
                if (iter_out_valid) begin
                    iter_remove = (nx <= -PW_S);
                    score_inc   = (cur_x + PW_S >= BIRD_S) && (nx + PW_S < BIRD_S);
                end else begin
                    state_nxt = SPAWN;
                end
            end
            SPAWN: begin
                insert_en = do_spawn;
                state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; everything freezes while ce is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     state <= IDLE;
        else if (ce) state <= state_nxt;
    end

    // One-deep frame queue: a tick arriving mid-frame is remembered once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (ce) begin
            if (state == IDLE)   pending <= 1'b0;
            else if (frame_tick) pending <= 1'b1;
        end
    end

    // Frames since the last spawn, saturating so a blocked spawn retries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt <= 8'd0;
        end else if (ce && state == SPAWN) begin
            if (do_spawn)        spawn_cnt <= 8'd0;
            else if (!spawn_due) spawn_cnt <= spawn_cnt + 8'd1;
        end
    end

    // Free-running Fibonacci LFSR, taps 16/14/13/11, stepping every ce cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     lfsr <= 16'hACE1;
        else if (ce) lfsr <= {lfsr_fb, lfsr[15:1]};
    end

endmodule

// File: tb/tb_pipes_scroller.sv
// Bench for pipes_scroller: emulates the pipe list around the DUT and keeps
// a frame-level reference model (list of pipes, spawn counter, LFSR) that is
// compared against the emulated list after every completed frame.
`timescale 1ns/1ps

module tb_pipes_scroller;

    localparam int SCREEN_WIDTH   = 640;
    localparam int PIPE_WIDTH     = 64;
    localparam int SPEED          = 2;
    localparam int BIRD_X         = 160;
    localparam int SPAWN_INTERVAL = 3;
    localparam int GAP_MIN        = 64;
    localparam int GAP_RANGE      = 288;
    localparam int MAX_PIPES      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        frame_tick = 1'b0;
    logic [4:0]  count = '0;
    logic        insert_en;
    logic [20:0] insert_data;
    logic        iter_start;
    logic [20:0] iter_out = '0;
    logic        iter_out_valid = 1'b0;
    logic [20:0] iter_in;
    logic        iter_remove;
    logic        score_inc;
    logic        busy;
    logic        frame_done;

    pipes_scroller #(
        .SCREEN_WIDTH(SCREEN_WIDTH), .PIPE_WIDTH(PIPE_WIDTH), .SPEED(SPEED),
        .BIRD_X(BIRD_X), .SPAWN_INTERVAL(SPAWN_INTERVAL), .GAP_MIN(GAP_MIN),
        .GAP_RANGE(GAP_RANGE), .MAX_PIPES(MAX_PIPES)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .frame_tick(frame_tick), .count(count),
        .insert_en(insert_en), .insert_data(insert_data), .iter_start(iter_start),
        .iter_out(iter_out), .iter_out_valid(iter_out_valid), .iter_in(iter_in),
        .iter_remove(iter_remove), .score_inc(score_inc), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Emulated pipe list
    logic [20:0] hl[$];
    logic [20:0] hnew[$];
    int          hphase = 0;
    int          hidx = 0;

    // Reference model
    logic [20:0] ml[$];
    int          mspawn = 0;
    logic [15:0] mlfsr = 16'hACE1;
    logic [15:0] mlfsr_prev = 16'hACE1;

    // Per-frame observations
    int          fr_start = 0, fr_score = 0, fr_ins = 0;
    logic [20:0] fr_ins_data = '0;
    int          frames = 0, last_score = 0, last_ins = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= l[16 - taps[i]];
        return {fb, l[15:1]};
    endfunction

    function automatic logic [9:0] gap_of(input logic [15:0] l);
        int raw = int'(l[8:0]);
        return 10'(GAP_MIN + ((raw >= GAP_RANGE) ? raw - GAP_RANGE : raw));
    endfunction

    function automatic logic [20:0] mkp(input int x, input int g);
        return {11'(x), 10'(g)};
    endfunction

    task automatic drive_inputs();
        count          = 5'(hl.size());
        iter_out_valid = (hphase == 2) && (hidx < hl.size());
        iter_out       = iter_out_valid ? hl[hidx] : '0;
    endtask

    task automatic set_both(input logic [20:0] q[$]);
        hl = q;
        ml = q;
        drive_inputs();
    endtask

    // Frame-level expectation: scroll, drop, score, then maybe spawn
    task automatic scoreboard_frame();
        logic [20:0] nl[$];
        int          exp_score = 0;
        int          exp_ins;
        logic [20:0] exp_new = '0;
        int          bad = -1;
        foreach (ml[i]) begin
            logic signed [10:0] xs;
            int x, nx;
            xs = ml[i][20:10];
            x  = xs;
            nx = x - SPEED;
            if (x + PIPE_WIDTH >= BIRD_X && nx + PIPE_WIDTH < BIRD_X) exp_score++;
            if (nx > -PIPE_WIDTH) nl.push_back({11'(nx), ml[i][9:0]});
        end
        exp_ins = (mspawn >= SPAWN_INTERVAL - 1 && nl.size() < MAX_PIPES) ? 1 : 0;
        if (exp_ins == 1) begin
            exp_new = {11'(SCREEN_WIDTH), gap_of(mlfsr_prev)};
            nl.push_back(exp_new);
            mspawn = 0;
        end else if (mspawn < SPAWN_INTERVAL - 1) begin
            mspawn++;
        end
        vectors++;
        if (fr_start !== 1) begin
            errors++; $display("FAIL iter_start_count: got %0d expected 1", fr_start);
        end
        vectors++;
        if (fr_score !== exp_score) begin
            errors++; $display("FAIL score_pulses: got %0d expected %0d", fr_score, exp_score);
        end
        vectors++;
        if (fr_ins !== exp_ins) begin
            errors++; $display("FAIL insert_count: got %0d expected %0d", fr_ins, exp_ins);
        end
        if (exp_ins == 1) begin
            vectors++;
            if (fr_ins_data !== exp_new) begin
                errors++; $display("FAIL insert_data: got %h expected %h", fr_ins_data, exp_new);
            end
        end
        vectors++;
        if (hl.size() != nl.size()) begin
            errors++; $display("FAIL list_size: got %0d expected %0d", hl.size(), nl.size());
        end else begin
            foreach (nl[i]) if (bad < 0 && hl[i] !== nl[i]) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL list_entry[%0d]: got %h expected %h", bad, hl[bad], nl[bad]);
            end
        end
        last_score = fr_score;
        last_ins   = fr_ins;
        frames++;
        ml = nl;
        fr_start = 0; fr_score = 0; fr_ins = 0;
    endtask

    // One clock: sample at negedge, let the list react at posedge
    task automatic step(input bit tick, input bit c);
        bit          st, ins, rem, sc, fd, v;
        logic [20:0] ii, id;
        frame_tick = tick;
        ce         = c;
        drive_inputs();
        @(negedge clk);
        st = iter_start; ins = insert_en; rem = iter_remove; sc = score_inc;
        fd = frame_done; v = iter_out_valid; ii = iter_in; id = insert_data;
        if (ins) begin
            vectors++;
            if (v) begin
                errors++; $display("FAIL insert_vs_valid: insert_en=1 expected 0 while valid");
            end
        end
        if (c) begin
            if (st) fr_start++;
            if (sc) fr_score++;
            if (ins) begin fr_ins++; fr_ins_data = id; end
            if (fd) scoreboard_frame();
        end
        @(posedge clk);
        #1;
        if (c) begin
            mlfsr_prev = mlfsr;
            mlfsr      = lfsr_step(mlfsr);
            if (st) begin
                hphase = 1; hidx = 0; hnew.delete();
            end else if (hphase == 1) begin
                hphase = 2;
            end else if (hphase == 2) begin
                if (v) begin
                    if (!rem) hnew.push_back(ii);
                    hidx++;
                end else begin
                    hl = hnew; hphase = 0;
                end
            end
            if (ins) hl.push_back(id);
        end
        frame_tick = 1'b0;
        drive_inputs();
    endtask

    task automatic run_frame(input bit rand_ce, output int lat);
        int f0 = frames;
        int n = 0;
        bit stalled = 0;
        step(1'b1, 1'b1);
        while (frames == f0 && n < 400) begin
            bit c = rand_ce ? ($urandom_range(3) != 0) : 1'b1;
            if (!c) stalled = 1;
            step(1'b0, c);
            n++;
        end
        if (frames == f0) begin
            vectors++; errors++;
            $display("FAIL frame_timeout: got no frame_done expected one within 400 cycles");
        end
        lat = stalled ? -1 : n;
    endtask

    task automatic apply_reset();
        rst = 1'b1; ce = 1'b0; frame_tick = 1'b0;
        hl.delete(); hnew.delete(); ml.delete();
        hphase = 0; hidx = 0; mspawn = 0;
        fr_start = 0; fr_score = 0; fr_ins = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mlfsr = 16'hACE1; mlfsr_prev = 16'hACE1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++;
        if ({busy, iter_start, insert_en, frame_done} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, iter_start, insert_en, frame_done});
        end
        vectors++;
        if ({iter_remove, score_inc} !== 2'b0) begin
            errors++; $display("FAIL reset_walk: got %b expected 00", {iter_remove, score_inc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_spawn();
        int lat;
        run_frame(1'b0, lat);
        vectors++;
        if (lat != 5) begin
            errors++; $display("FAIL empty_latency: got %0d expected 5", lat);
        end
        run_frame(1'b0, lat);
        run_frame(1'b0, lat);
        vectors++;
        if (last_ins != 1 || hl.size() != 1) begin
            errors++; $display("FAIL empty_spawn: got ins=%0d size=%0d expected ins=1 size=1", last_ins, hl.size());
        end else begin
            vectors++;
            if (hl[0][20:10] !== 11'd640) begin
                errors++; $display("FAIL spawn_x: got %0d expected 640", hl[0][20:10]);
            end
        end
    endtask

    task automatic test_scroll();
        logic [20:0] q[$];
        int lat;
        q.push_back(mkp(100, 200));
        set_both(q);
        run_frame(1'b0, lat);
        vectors++;
        if (hl[0] !== mkp(98, 200) || last_score != 0) begin
            errors++; $display("FAIL scroll: got %h score=%0d expected %h score=0", hl[0], last_score, mkp(98, 200));
        end
        vectors++;
        if (lat != 6) begin
            errors++; $display("FAIL one_pipe_latency: got %0d expected 6", lat);
        end
    endtask

    task automatic test_remove();
        logic [20:0] q[$];
        int lat;
        q.push_back(mkp(-63, 10));
        q.push_back(mkp(300, 20));
        set_both(q);
        run_frame(1'b0, lat);
        vectors++;
        if (hl[0] !== mkp(298, 20)) begin
            errors++; $display("FAIL remove: got head %h expected %h", hl[0], mkp(298, 20));
        end
    endtask

    task automatic test_score();
        logic [20:0] q[$];
        int lat;
        q.push_back(mkp(97, 77));
        set_both(q);
        run_frame(1'b0, lat);
        vectors++;
        if (last_score != 1) begin
            errors++; $display("FAIL score_cross: got %0d expected 1", last_score);
        end
        run_frame(1'b0, lat);
        vectors++;
        if (last_score != 0) begin
            errors++; $display("FAIL score_after: got %0d expected 0", last_score);
        end
    endtask

    task automatic test_full_list();
        logic [20:0] q[$];
        int lat;
        q.push_back(mkp(-57, 5));
        for (int i = 0; i < 15; i++) q.push_back(mkp(300 + i * 20, i));
        set_both(q);
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, lat);
            vectors++;
            if (last_ins != 0) begin
                errors++; $display("FAIL full_block[%0d]: got ins=%0d expected 0", f, last_ins);
            end
        end
        run_frame(1'b0, lat);
        vectors++;
        if (last_ins != 1 || hl.size() != 16) begin
            errors++; $display("FAIL full_retry: got ins=%0d size=%0d expected ins=1 size=16", last_ins, hl.size());
        end
    endtask

    task automatic test_pending();
        logic [20:0] q[$];
        int f0 = frames;
        int n = 0;
        q.push_back(mkp(400, 1));
        q.push_back(mkp(500, 2));
        set_both(q);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        while (frames < f0 + 2 && n < 400) begin
            step(1'b0, 1'b1);
            n++;
        end
        repeat (20) step(1'b0, 1'b1);
        vectors++;
        if (frames != f0 + 2) begin
            errors++; $display("FAIL pending_frames: got %0d expected %0d", frames - f0, 2);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL pending_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_ce_freeze();
        int f0 = frames;
        int n = 0;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL ce_freeze_busy: got %b expected 1", busy);
            end
        end
        while (frames == f0 && n < 400) begin
            step(1'b0, 1'b1);
            n++;
        end
        repeat (10) step(1'b0, 1'b1);
        vectors++;
        if (frames != f0 + 1) begin
            errors++; $display("FAIL ce_freeze_frames: got %0d expected 1", frames - f0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int lat, n0;
            bit rc;
            if ($urandom_range(1) == 1) begin
                logic [20:0] q[$];
                int sz = $urandom_range(16);
                for (int k = 0; k < sz; k++)
                    q.push_back(mkp(int'($urandom_range(780)) - 70, int'($urandom_range(1023))));
                set_both(q);
            end
            n0 = hl.size();
            rc = (it % 2 == 1);
            run_frame(rc, lat);
            if (lat >= 0) begin
                vectors++;
                if (lat != 5 + n0) begin
                    errors++; $display("FAIL rand_latency: got %0d expected %0d", lat, 5 + n0);
                end
            end
        end
    endtask

    task automatic test_rst_mid_walk();
        logic [20:0] q[$];
        q.push_back(mkp(-63, 3));
        q.push_back(mkp(97, 4));
        set_both(q);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        ce = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, iter_remove} !== 2'b11) begin
            errors++; $display("FAIL mid_walk_remove: got %b expected 11", {busy, iter_remove});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, iter_start, insert_en, iter_remove, score_inc, frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_walk: got %b expected 000000",
                     {busy, iter_start, insert_en, iter_remove, score_inc, frame_done});
        end
        apply_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_empty_spawn();
        test_scroll();
        test_remove();
        test_score();
        test_full_list();
        test_pending();
        test_ce_freeze();
        test_random();
        test_rst_mid_walk();
        test_empty_spawn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
